// File: rtl/mem_arbiter.sv
// Two-requester (I-fetch / D-access) arbiter onto a single fixed-latency memory port.
// One transaction in flight at a time; D has priority, bounded by a starvation counter.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_req_write,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [1:0]            state_dbg
);

    // Handshake: a request transfers in the cycle where valid && ready; ready is
    // combinational, only ever high in IDLE, and only for the granted requester.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [3:0] LAT_LAST   = 4'(MEM_LATENCY - 1);

    state_t     state, next_state;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       owner_d;
    logic       owner_wr;
    logic       grant_i, grant_d;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE && !rst) begin
            grant_d = d_req_valid && !(i_req_valid && starve_cnt == STARVE_MAX);
            grant_i = i_req_valid && !grant_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
            owner_d    <= 1'b0;
            owner_wr   <= 1'b0;
        end else begin
            state <= next_state;
            if (grant_i || grant_d) begin
                owner_d  <= grant_d;
                owner_wr <= grant_d && d_req_write;
                lat_cnt  <= 4'd1;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt + 4'd1;
            end
            // Count only D wins that actually pushed a waiting I aside.
            if (grant_d && i_req_valid) begin
                starve_cnt <= starve_cnt + 4'd1;
            end else if (grant_d || grant_i) begin
                starve_cnt <= 4'd0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_i || grant_d) begin
                    next_state = (MEM_LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        i_req_ready      = grant_i;
        d_req_ready      = grant_d;
        mem_read_enable  = grant_i || (grant_d && !d_req_write);
        mem_write_enable = grant_d && d_req_write;
        mem_addr         = '0;
        mem_write_data   = '0;
        i_resp_valid     = 1'b0;
        i_resp_data      = '0;
        d_resp_valid     = 1'b0;
        d_resp_data      = '0;
        state_dbg        = rst ? 2'd0 : state;
        if (grant_i) begin
            mem_addr = i_req_addr;
        end else if (grant_d) begin
            mem_addr = d_req_addr;
            if (d_req_write) begin
                mem_write_data = d_req_wdata;
            end
        end
        // Reset mid-transaction suppresses the response pulse in the rst cycle itself.
        if (state == RESP && !rst) begin
            if (owner_d) begin
                d_resp_valid = 1'b1;
                d_resp_data  = owner_wr ? '0 : mem_read_data;
            end else begin
                i_resp_valid = 1'b1;
                i_resp_data  = mem_read_data;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the address bus width.
REQ-003 SHALL have parameter MEM_LATENCY, default 1, the cycles from memory issue to valid mem_read_data; legal range is 1..15.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, the maximum consecutive D grants allowed while I is pending; legal range is 1..15.
REQ-005 SHALL have ports clk in 1, the single rising-edge clock, and rst in 1, the reset; reset is synchronous and active-high.
REQ-006 SHALL have I-fetch request ports: i_req_valid in 1; i_req_ready out 1; i_req_addr in ADDR_WIDTH.
REQ-007 SHALL have I-fetch response ports: i_resp_valid out 1; i_resp_data out DATA_WIDTH.
REQ-008 SHALL have D-access request ports: d_req_valid in 1; d_req_ready out 1; d_req_write in 1; d_req_addr in ADDR_WIDTH; d_req_wdata in DATA_WIDTH.
REQ-009 SHALL have D-access response ports: d_resp_valid out 1; d_resp_data out DATA_WIDTH.
REQ-010 SHALL have memory-side ports: mem_read_enable out 1; mem_write_enable out 1; mem_addr out ADDR_WIDTH; mem_write_data out DATA_WIDTH; mem_read_data in DATA_WIDTH.

Function
REQ-011 SHALL implement states IDLE, WAIT and RESP, with at most one transaction outstanding.
REQ-012 SHALL assert a requester's ready, combinationally and only in IDLE, for the granted requester; a handshake is valid AND ready in cycle T.
REQ-013 SHALL drive mem_addr, mem_write_data, mem_read_enable and mem_write_enable from the granted request in cycle T only; the enables SHALL be 0 in every other cycle.
REQ-014 SHALL apply the following enable rules:
- I grant: mem_read_enable=1.
- D grant with d_req_write=0: mem_read_enable=1.
- D grant with d_req_write=1: mem_write_enable=1, mem_write_data=d_req_wdata.
REQ-015 SHALL sequence states after issue: WAIT for cycles T+1..T+MEM_LATENCY-1; RESP at T+MEM_LATENCY; IDLE at T+MEM_LATENCY+1.
REQ-016 SHALL go IDLE -> RESP directly when MEM_LATENCY=1.
REQ-017 SHALL, in RESP, pulse the owner's resp_valid for exactly one cycle.
REQ-018 SHALL set resp_data=mem_read_data for a read and resp_data=0 for a write ack, and hold the non-owner's resp_valid at 0.
REQ-019 SHALL hold resp_data at 0 whenever resp_valid=0.
REQ-020 SHALL give D priority over I when both are valid in IDLE.
REQ-021 SHALL maintain a 4-bit starvation counter that increments on each D grant made while i_req_valid=1 and clears on any I grant or on any D grant made with i_req_valid=0.
REQ-022 SHALL grant I instead of D when the starvation counter equals STARVE_LIMIT and both are valid.
REQ-023 SHALL treat the sustained rate of one transaction per MEM_LATENCY+1 cycles as the correct throughput and keep ready at 0 in WAIT and RESP.
REQ-024 SHALL ignore valid and request payloads outside IDLE; requesters hold valid and payload stable until the handshake, and withdrawal before the handshake is a protocol violation with unspecified behaviour.
REQ-025 SHALL remain in IDLE with all enables at 0 when no request is valid.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set the state to IDLE and the starvation counter to 0, and drive every output to 0, including the ready signals.
REQ-027 SHALL, on reset mid-transaction in WAIT or RESP, abandon the transaction with no resp_valid pulse, either in the rst cycle or afterwards.
REQ-028 SHALL be able to accept a handshake in the first cycle after rst deasserts.

Verification
REQ-029 SHALL cover a single I read with MEM_LATENCY=2: i_req_valid at T with addr 0x10 -> i_req_ready=1 and mem_read_enable=1 at T, i_resp_valid=1 at T+2 with data = mem_read_data, next ready at T+3.
REQ-030 SHALL cover simultaneous I and D in IDLE -> D granted at T, I granted at T+MEM_LATENCY+1, each response routed only to its owner.
REQ-031 SHALL cover a D write of addr 0x20 and data 0xDEADBEEF -> mem_write_enable=1 and mem_read_enable=0 at T, d_resp_valid pulse with d_resp_data=0 at T+MEM_LATENCY.
REQ-032 SHALL cover starvation with STARVE_LIMIT=4, both requesters valid continuously -> grants D,D,D,D,I,D,D,D,D,I.
REQ-033 SHALL cover rst asserted in WAIT with MEM_LATENCY=3 -> no resp_valid at any later cycle, all outputs 0, and a new request accepted the cycle after rst drops.
REQ-034 SHALL cover MEM_LATENCY=1 back-to-back I requests -> handshakes at T, T+2, T+4, with i_resp_valid at T+1, T+3, T+5.
